// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the program loader.
package prog_loader_pkg;

   localparam int unsigned ADDR_W_DEF  = 10;
   localparam int unsigned INSTR_W_DEF = 9;
   localparam int unsigned CNT_W       = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

endpackage

// File: rtl/prog_loader_sat_counter.sv
// Clear/enable counter that sticks at all-ones instead of wrapping.
module sat_counter
   import prog_loader_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Clr,
   input  logic         En,
   output logic [W-1:0] Count
);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         Count <= '0;
      else if (Clr)
         Count <= '0;
      else if (En && (Count != '1))
         Count <= Count + W'(1);
   end

endmodule

// File: rtl/prog_loader.sv
// Streams a host program into instruction memory, starts the processor and times its run.
// Optional run timeout enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned      ADDR_W  = ADDR_W_DEF,
   parameter int unsigned      INSTR_W = INSTR_W_DEF,
   parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFF0
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               LoadValid,
   output logic               LoadReady,
   input  logic [INSTR_W-1:0] LoadData,
   input  logic               LoadLast,
   output logic               ImemWe,
   output logic [ADDR_W-1:0]  ImemAddr,
   output logic [INSTR_W-1:0] ImemData,
   output logic               Start,
   input  logic               Ack,
   output logic               Busy,
   output logic               Done,
   output logic               Error,
   output logic [CNT_W-1:0]   CycleCount
);

`ifdef PROG_LOADER_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   state_t            state, state_n;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] cur_addr;
   logic              accept;
   logic              at_top;
   logic              timeout_hit;
   logic              cnt_clr;
   logic              cnt_en;

   assign LoadReady = (state == S_IDLE) || (state == S_LOAD) || (state == S_DONE);
   assign accept    = LoadValid && LoadReady;
   // A fresh program (from IDLE or DONE) always starts at address zero.
   assign cur_addr  = (state == S_LOAD) ? ptr : '0;
   assign at_top    = (cur_addr == '1);
   assign timeout_hit = TIMEOUT_EN && (CycleCount == TIMEOUT);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ptr      <= '0;
         ImemWe   <= 1'b0;
         ImemAddr <= '0;
         ImemData <= '0;
      end else begin
         ImemWe <= accept;
         if (accept) begin
            ImemAddr <= cur_addr;
            ImemData <= LoadData;
            ptr      <= at_top ? cur_addr : cur_addr + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      state_n = state;
      Start   = 1'b0;
      Busy    = 1'b0;
      Done    = 1'b0;
      Error   = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state)
         S_IDLE, S_LOAD, S_DONE: begin
            Busy = (state == S_LOAD);
            Done = (state == S_DONE);
            if (accept) begin
               if (at_top && !LoadLast)
                  state_n = S_ERR;
               else if (LoadLast)
                  state_n = S_START;
               else
                  state_n = S_LOAD;
            end
         end
         S_START: begin
            Start   = 1'b1;
            Busy    = 1'b1;
            cnt_clr = 1'b1;
            state_n = S_RUN;
         end
         S_RUN: begin
            Busy = 1'b1;
            // The Ack cycle and the timeout cycle are not counted.
            if (Ack)
               state_n = S_DONE;
            else if (timeout_hit)
               state_n = S_ERR;
            else
               cnt_en = 1'b1;
         end
         S_ERR: begin
            Error = 1'b1;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   sat_counter #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .Clr   (cnt_clr),
      .En    (cnt_en),
      .Count (CycleCount)
   );

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, instruction-memory address width (1024 words).
REQ-002 Parameter INSTR_W, default 9, instruction word width.
REQ-003 Parameter TIMEOUT, default 16'hFFF0, run-cycle limit before error (used only with PROG_LOADER_TIMEOUT_EN).
REQ-004 Clk  input  1  single clock; all state updates on posedge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 LoadValid  input  1  host instruction word valid.
REQ-007 LoadReady  output  1  loader can accept a word.
REQ-008 LoadData  input  INSTR_W  host instruction word.
REQ-009 LoadLast  input  1  qualifies the final word of a program.
REQ-010 ImemWe  output  1  instruction-memory write enable.
REQ-011 ImemAddr  output  ADDR_W  instruction-memory write address.
REQ-012 ImemData  output  INSTR_W  instruction-memory write data.
REQ-013 Start  output  1  start pulse to processor.
REQ-014 Ack  input  1  processor done flag.
REQ-015 Busy  output  1  high in LOAD, START, RUN.
REQ-016 Done  output  1  program completed.
REQ-017 Error  output  1  overflow or timeout occurred.
REQ-018 CycleCount  output  16  processor run cycles of the last/current program.

Function
REQ-019 FSM states: IDLE, LOAD, START, RUN, DONE, ERR.
REQ-020 Word accepted on posedge when LoadValid && LoadReady; LoadReady = 1 in IDLE, LOAD, DONE; 0 elsewhere.
REQ-021 Accepted word written one cycle later: ImemWe = 1 for exactly one cycle, ImemData = word, ImemAddr = write pointer.
REQ-022 Write pointer = 0 on first word accepted from IDLE or DONE; increments by 1 per accepted word.
REQ-023 IDLE/DONE -> LOAD on accepted word without LoadLast; -> START on accepted word with LoadLast (single-word program).
REQ-024 LOAD -> START on accepted word with LoadLast.
REQ-025 Word accepted at pointer 2^ADDR_W-1 without LoadLast -> ERR; that word is still written, pointer does not wrap.
REQ-026 START: Start = 1 for exactly one cycle, CycleCount cleared to 0, Ack ignored; then -> RUN.
REQ-027 RUN: CycleCount += 1 each cycle Ack == 0; saturates at 16'hFFFF; Ack == 1 -> DONE, CycleCount frozen (cycle with Ack high not counted).
REQ-028 DONE: Done = 1, CycleCount held until next START.
REQ-029 ERR: Error = 1, LoadReady = 0, Start = 0; exits only via Reset.
REQ-030 LoadValid in START/RUN/ERR is not accepted (LoadReady = 0); host holds word.

Reset
REQ-031 Reset low asynchronously forces IDLE, pointer 0, CycleCount 0, ImemWe 0, Start 0, Done 0, Error 0, Busy 0; LoadReady = 1 after release.
REQ-032 Reset mid-LOAD or mid-RUN discards progress; no ImemWe pulse after reset assertion.

Configuration
REQ-033 Macro PROG_LOADER_TIMEOUT_EN defined: in RUN, CycleCount == TIMEOUT with Ack == 0 -> ERR.
REQ-034 Macro undefined: no timeout; RUN waits indefinitely for Ack; TIMEOUT unused.

Structure
REQ-035 Package prog_loader_pkg holds state enum type, ADDR_W/INSTR_W defaults, counter width constant.
REQ-036 One sub-module natural: sat_counter (16-bit clear/enable saturating counter) for CycleCount.

Verification
REQ-037 Load 3 words 9'h041, 9'h0C2, 9'h1C0 (last) -> ImemWe pulses at addr 0,1,2 with those data; Start single pulse next.
REQ-038 After Start, Ack held 0 for 10 cycles then 1 -> Done = 1, CycleCount = 10, Busy = 0.
REQ-039 1024 words, none LoadLast -> Error = 1 after word 1023, LoadReady = 0, Start never asserted.
REQ-040 PROG_LOADER_TIMEOUT_EN, TIMEOUT = 20, Ack held 0 -> Error = 1 with CycleCount = 20; macro undefined -> still RUN at 100 cycles.
REQ-041 Reset asserted in RUN cycle 5 -> all outputs at reset values immediately; new single-word program then loads at addr 0.
